// File: rtl/matvec_pkg.sv
// Shared types and constants for the matrix-vector sequencer.
// State encoding, CSR address map and CTRL bit positions.
package matvec_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        CAL,
        DRAIN,
        READ,
        DONE
    } state_t;

    localparam logic [1:0] ADDR_ROW  = 2'd0;
    localparam logic [1:0] ADDR_COL  = 2'd1;
    localparam logic [1:0] ADDR_CTRL = 2'd2;
    localparam logic [1:0] ADDR_RSVD = 2'd3;

    localparam int CTRL_START   = 0;
    localparam int CTRL_ABORT   = 1;
    localparam int CTRL_ERR_CLR = 2;

endpackage

// File: rtl/matvec_csr_regs.sv
// CSR write decode: size registers, start/abort pulses, sticky error.
// Size writes and starts are locked out while a sequence is running.
module matvec_csr_regs
    import matvec_pkg::*;
#(
    parameter int SIZE_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              csr_valid,
    input  logic [1:0]        csr_addr,
    input  logic [DATA_W-1:0] csr_data,
    input  logic              busy,
    output logic              start,
    output logic              abort,
    output logic [SIZE_W-1:0] row_size,
    output logic [SIZE_W-1:0] col_size,
    output logic              err
);

    logic wr_row;
    logic wr_col;
    logic wr_ctrl;
    logic wr_rsvd;
    logic req_start;
    logic err_set;
    logic err_clr;
    logic data_unused;

    assign wr_row  = csr_valid && (csr_addr == ADDR_ROW);
    assign wr_col  = csr_valid && (csr_addr == ADDR_COL);
    assign wr_ctrl = csr_valid && (csr_addr == ADDR_CTRL);
    assign wr_rsvd = csr_valid && (csr_addr == ADDR_RSVD);

    // Abort wins over start when both bits arrive in one write.
    assign req_start = wr_ctrl && csr_data[CTRL_START]
                     && !csr_data[CTRL_ABORT];
    assign abort     = wr_ctrl && csr_data[CTRL_ABORT];
    assign start     = req_start && !busy;
    assign err_clr   = wr_ctrl && csr_data[CTRL_ERR_CLR];
    assign err_set   = wr_rsvd
                     || (busy && (wr_row || wr_col || req_start));

    // Upper data bits carry nothing for this block.
    assign data_unused = ^csr_data;

    // Size registers only move while idle; err set beats err clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_size <= '0;
            col_size <= '0;
            err      <= 1'b0;
        end else begin
            if (wr_row && !busy) begin
                row_size <= csr_data[SIZE_W-1:0];
            end
            if (wr_col && !busy) begin
                col_size <= csr_data[SIZE_W-1:0];
            end
            if (err_set) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/matvec_seq_ctrl.sv
// Sequencer for the systolic matrix-vector PE array.
// Runs clear, compute, pipeline drain and readout per start command.
module matvec_seq_ctrl
    import matvec_pkg::*;
#(
    parameter int SIZE_W   = 8,
    parameter int DATA_W   = 32,
    parameter int PIPE_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              csr_valid,
    output logic              csr_ready,
    input  logic [1:0]        csr_addr,
    input  logic [DATA_W-1:0] csr_data,
    output logic              pe_clear,
    output logic              pe_en,
    output logic              pe_read,
    output logic [SIZE_W-1:0] read_idx,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [SIZE_W-1:0] DR_LAST =
        SIZE_W'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);

    state_t            state;
    logic              start;
    logic              abort;
    logic [SIZE_W-1:0] row_size;
    logic [SIZE_W-1:0] col_size;
    logic [SIZE_W-1:0] row_w;
    logic [SIZE_W-1:0] col_w;
    logic [SIZE_W-1:0] rd_cnt;
    logic [SIZE_W-1:0] dr_cnt;
    logic [SIZE_W:0]   cal_cnt;
    logic [SIZE_W:0]   cal_last;

    matvec_csr_regs #(
        .SIZE_W (SIZE_W),
        .DATA_W (DATA_W)
    ) u_regs (
        .clk       (clk),
        .reset     (reset),
        .csr_valid (csr_valid),
        .csr_addr  (csr_addr),
        .csr_data  (csr_data),
        .busy      (busy),
        .start     (start),
        .abort     (abort),
        .row_size  (row_size),
        .col_size  (col_size),
        .err       (err)
    );

    assign csr_ready = 1'b1;
    assign busy      = (state != IDLE);
    assign read_idx  = rd_cnt;

    // One extra bit so max+max cannot wrap.
    assign cal_last = {1'b0, row_w} + {1'b0, col_w};

    // Sequencer FSM with counters and registered strobes.
    always_ff @(posedge clk) begin
        if (reset || abort) begin
            state    <= IDLE;
            row_w    <= reset ? '0 : row_w;
            col_w    <= reset ? '0 : col_w;
            cal_cnt  <= '0;
            dr_cnt   <= '0;
            rd_cnt   <= '0;
            pe_clear <= 1'b0;
            pe_en    <= 1'b0;
            pe_read  <= 1'b0;
            done     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state    <= CLEAR;
                        row_w    <= row_size;
                        col_w    <= col_size;
                        pe_clear <= 1'b1;
                    end
                end
                CLEAR: begin
                    state    <= CAL;
                    pe_clear <= 1'b0;
                    pe_en    <= 1'b1;
                end
                CAL: begin
                    if (cal_cnt == cal_last) begin
                        cal_cnt <= '0;
                        pe_en   <= 1'b0;
                        if (PIPE_LAT == 0) begin
                            state   <= READ;
                            pe_read <= 1'b1;
                        end else begin
                            state <= DRAIN;
                        end
                    end else begin
                        cal_cnt <= cal_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (dr_cnt == DR_LAST) begin
                        dr_cnt  <= '0;
                        state   <= READ;
                        pe_read <= 1'b1;
                    end else begin
                        dr_cnt <= dr_cnt + 1'b1;
                    end
                end
                READ: begin
                    if (rd_cnt == col_w) begin
                        rd_cnt  <= '0;
                        state   <= DONE;
                        pe_read <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        rd_cnt <= rd_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/matvec_seq_ctrl.md
Name: matvec_seq_ctrl

Overview:
- Parametrised sequencer for the systolic matrix-vector unit.
- Accepts row/column size and control writes over a single CSR write channel.
- Sequences the PE array through clear, compute, pipeline drain and result readout, and reports busy/done/error status.
- Sits between the STM32-facing bus bridge and the PE array / result path.
- Adds over the first-generation controller: size-width parameter, overflow-free cycle arithmetic, abort, pipeline-latency drain, readout index, sticky error flag.

Parameters:
- SIZE_W, 8: width of the row/column size registers and all sequencing counters.
- DATA_W, 32: CSR data width; must be ≥ SIZE_W.
- PIPE_LAT, 2: PE array output latency in cycles, drained before readout (0 allowed).

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- csr_valid  in  1  CSR write strobe; one write per cycle while high
- csr_ready  out  1  write accepted this cycle (valid && ready)
- csr_addr  in  2  0=ROW_SIZE, 1=COL_SIZE, 2=CTRL, 3=reserved
- csr_data  in  DATA_W  write data; the low SIZE_W bits are used for sizes
- pe_clear  out  1  one-cycle accumulator clear to the PE array
- pe_en  out  1  PE array compute enable
- pe_read  out  1  result readout strobe
- read_idx  out  SIZE_W  column index of the current readout beat
- busy  out  1  sequence in progress (any state except IDLE)
- done  out  1  one-cycle completion pulse
- err  out  1  sticky error flag

Behaviour:
- Reset: state=IDLE; row_size=0, col_size=0, all counters=0, err=0.
- Outputs during reset and in IDLE: pe_clear, pe_en, pe_read, read_idx, busy and done are all 0.
- Size encoding: each size register holds dimension−1. A value of 0 means one element.
- csr_ready is constant 1; every write is consumed in one cycle.
- Size writes (addr 0/1) in IDLE update the register.
- Size writes while busy are dropped and set err.
- Addr 3 writes set err.
- CTRL bit0=start:
  - Honoured only in IDLE.
  - Start while busy is ignored and sets err.
- CTRL bit1=abort:
  - Honoured in any state.
  - Takes priority over start in the same write.
  - Next state is IDLE with counters cleared and no done pulse.
- CTRL bit2=err_clr: clears err. If an error event occurs in the same cycle, set wins.
- A write takes effect on the edge it is accepted. Start written in cycle N gives CLEAR in cycle N+1.
- FSM (registered outputs decoded from state):
  - IDLE → CLEAR on start.
  - CLEAR (1 cycle, pe_clear=1) → CAL.
  - CAL (pe_en=1): cal_cnt runs 0..row_size+col_size, i.e. row_size+col_size+1 cycles. Then → DRAIN, or → READ if PIPE_LAT=0.
  - DRAIN: PIPE_LAT cycles with all strobes 0 → READ.
  - READ (pe_read=1, read_idx=rd_cnt): rd_cnt runs 0..col_size, i.e. col_size+1 beats → DONE.
  - DONE (1 cycle, done=1, busy=1) → IDLE.
- Arithmetic: the cal terminal value is computed in SIZE_W+1 bits, so max+max does not wrap. Counters are cleared on every state exit.
- Sizes are snapshotted into working registers on start. The running sequence is immune to later CSR activity.
- Total latency, start accept to done: 1 + (R+C+1) + PIPE_LAT + (C+1) + 1 cycles (R/C = register values).
- Reset mid-sequence returns to IDLE on the next edge, with every output 0 the following cycle.

Decomposition:
- Package matvec_pkg:
  - state enum (IDLE, CLEAR, CAL, DRAIN, READ, DONE)
  - CSR address constants
  - CTRL bit positions (START, ABORT, ERR_CLR)
- One sub-module, matvec_csr_regs: size registers, CTRL decode, err logic. Outputs a start pulse, an abort pulse and size values, gated by busy.
- FSM and counters stay in the top module.

Test Plan:
- Basic run: ROW=3, COL=2, PIPE_LAT=2, start.
  - pe_clear for 1 cycle, then pe_en for 6 cycles, then 2 idle cycles.
  - Then pe_read for 3 beats with read_idx 0,1,2.
  - done pulses exactly 13 cycles after start accept; busy is high for those 13 cycles.
- Width boundary: SIZE_W=8, ROW=255, COL=255.
  - pe_en high for exactly 511 cycles (no wrap); readout gives 256 beats, read_idx 0..255.
- Minimal: ROW=0, COL=0, PIPE_LAT=0.
  - pe_en for 1 cycle, a single read beat with read_idx=0, done 4 cycles after accept.
- Abort: abort written on the 3rd CAL cycle.
  - IDLE next cycle; pe_en drops; no pe_read; no done; busy=0.
  - A following start runs a full, correct sequence.
- Protection: write COL=7 and start during CAL.
  - Running sequence still reads the original COL+1 beats; err=1 stays set.
  - err_clr clears err; the new COL=7 is not latched.
- Reset mid-READ: assert reset at read_idx=1.
  - Next cycle: all outputs 0, err=0, row/col=0.
  - Start then gives a single-beat (0,0) sequence.
